// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared geometry constants and scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  localparam int IMG        = 28;
  localparam int KSZ        = 5;
  localparam int OUT        = IMG - KSZ + 1;
  localparam int NKER       = 8;
  localparam int NCLS       = 10;
  localparam int CONV_JOBS  = NKER * OUT * OUT;
  localparam int ROW_STRIDE = 896;
  localparam int PIX_W      = 32;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CONV       = 3'd1,
    S_CONV_DRAIN = 3'd2,
    S_FC         = 3'd3,
    S_FC_DRAIN   = 3'd4,
    S_DONE       = 3'd5
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/cnn_idx_walker.sv
`default_nettype none
// ============================================================================
// Module      : cnn_idx_walker
// Description : Nested col/row/kernel wrap counter with registered window base.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_idx_walker
  import cnn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        adv,
  output logic [2:0]  kernel,
  output logic [4:0]  row,
  output logic [4:0]  col,
  output logic [14:0] base,
  output logic        last
);

  logic        w_col_wrap;
  logic        w_row_wrap;
  logic [2:0]  w_kernel_n;
  logic [4:0]  w_row_n;
  logic [4:0]  w_col_n;
  logic [14:0] w_base_n;

  always_comb begin
    w_col_wrap = (col == 5'(OUT - 1));
    w_row_wrap = (row == 5'(OUT - 1));
    w_col_n    = w_col_wrap ? 5'd0 : col + 5'd1;
    w_row_n    = row;
    w_kernel_n = kernel;
    if (w_col_wrap) begin
      w_row_n = w_row_wrap ? 5'd0 : row + 5'd1;
      if (w_row_wrap)
        w_kernel_n = (kernel == 3'(NKER - 1)) ? 3'd0 : kernel + 3'd1;
    end
    // 896*row as 512+256+128, 32*col as a shift
    w_base_n = (15'(w_row_n) << 9) + (15'(w_row_n) << 8) + (15'(w_row_n) << 7)
             + (15'(w_col_n) << 5);
    last     = (kernel == 3'(NKER - 1)) && w_row_wrap && w_col_wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kernel <= 3'd0;
      row    <= 5'd0;
      col    <= 5'd0;
      base   <= 15'd0;
    end else if (clr) begin
      kernel <= 3'd0;
      row    <= 5'd0;
      col    <= 5'd0;
      base   <= 15'd0;
    end else if (adv) begin
      kernel <= w_kernel_n;
      row    <= w_row_n;
      col    <= w_col_n;
      base   <= w_base_n;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnn_layer_sched.sv
`default_nettype none
// ============================================================================
// Module      : cnn_layer_sched
// Description : Sequences conv jobs then FC jobs under a per-phase credit limit.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_layer_sched
  import cnn_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        conv_valid,
  input  logic        conv_ready,
  output logic [2:0]  conv_kernel,
  output logic [4:0]  conv_row,
  output logic [4:0]  conv_col,
  output logic [14:0] conv_base,
  input  logic        conv_res_valid,
  output logic        fc_valid,
  input  logic        fc_ready,
  output logic [3:0]  fc_neuron,
  input  logic        fc_res_valid
);

  sched_state_t r_state, w_state_n;
  logic [12:0]  r_conv_out, r_conv_ret, r_fc_out;
  logic [3:0]   r_fc_ret, r_fc_idx;
  logic         r_err;
  logic         w_start_acc, w_conv_hs, w_fc_hs, w_conv_last;
  logic         w_conv_ok, w_fc_ok, w_conv_bad, w_fc_bad;

  cnn_idx_walker u_walker (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_start_acc),
    .adv    (w_conv_hs),
    .kernel (conv_kernel),
    .row    (conv_row),
    .col    (conv_col),
    .base   (conv_base),
    .last   (w_conv_last)
  );

  always_comb begin
    w_state_n   = r_state;
    w_start_acc = start && (r_state == S_IDLE);
    // credit is judged on the registered count only, so a same-cycle return never opens it
    conv_valid  = (r_state == S_CONV) && (r_conv_out < 13'(MAX_OUT));
    fc_valid    = (r_state == S_FC) && (r_fc_out < 13'(MAX_OUT));
    w_conv_hs   = conv_valid && conv_ready;
    w_fc_hs     = fc_valid && fc_ready;
    w_conv_ok   = conv_res_valid && (r_conv_out != 13'd0)
                  && ((r_state == S_CONV) || (r_state == S_CONV_DRAIN));
    w_fc_ok     = fc_res_valid && (r_fc_out != 13'd0)
                  && ((r_state == S_FC) || (r_state == S_FC_DRAIN));
    w_conv_bad  = conv_res_valid && !w_conv_ok;
    w_fc_bad    = fc_res_valid && !w_fc_ok;
    unique case (r_state)
      S_IDLE:       if (w_start_acc) w_state_n = S_CONV;
      S_CONV:       if (w_conv_hs && w_conv_last) w_state_n = S_CONV_DRAIN;
      S_CONV_DRAIN: if ((r_conv_ret + 13'(w_conv_ok)) == 13'(CONV_JOBS)) w_state_n = S_FC;
      S_FC:         if (w_fc_hs && (r_fc_idx == 4'(NCLS - 1))) w_state_n = S_FC_DRAIN;
      S_FC_DRAIN:   if ((r_fc_ret + 4'(w_fc_ok)) == 4'(NCLS)) w_state_n = S_DONE;
      S_DONE:       w_state_n = S_IDLE;
      default:      w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_conv_out <= 13'd0;
      r_conv_ret <= 13'd0;
      r_fc_out   <= 13'd0;
      r_fc_ret   <= 4'd0;
      r_fc_idx   <= 4'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_start_acc) begin
        r_conv_out <= 13'd0;
        r_conv_ret <= 13'd0;
        r_fc_out   <= 13'd0;
        r_fc_ret   <= 4'd0;
        r_fc_idx   <= 4'd0;
        r_err      <= 1'b0;
      end else begin
        r_conv_out <= r_conv_out + 13'(w_conv_hs) - 13'(w_conv_ok);
        r_conv_ret <= r_conv_ret + 13'(w_conv_ok);
        r_fc_out   <= r_fc_out + 13'(w_fc_hs) - 13'(w_fc_ok);
        r_fc_ret   <= r_fc_ret + 4'(w_fc_ok);
        if (w_fc_hs)
          r_fc_idx <= r_fc_idx + 4'd1;
        if (w_conv_bad || w_fc_bad)
          r_err <= 1'b1;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign fc_neuron = r_fc_idx;

endmodule
`default_nettype wire

// File: doc/cnn_layer_sched.md
# cnn_layer_sched

Layer scheduler for the SimpleCNN datapath: once the image (28×28), eight 5×5 conv kernels and ten 1152-entry FC weight vectors are loaded, this block sequences the shared conv engine over every (kernel, row, col) output position, then the FC engine over the ten class neurons. It issues one job per handshake, tracks outstanding results with a credit limit, and signals completion of the whole inference. It sits between the top-level controller (`start`/`done`) and the conv/FC compute units that consume the loaded data and weight buses.

## Interface
- `IMG` = 28: input image side, in pixels.
- `KSZ` = 5: conv kernel side.
- `NKER` = 8: number of conv kernels.
- `NCLS` = 10: number of FC output neurons.
- `MAX_OUT` = 4: maximum jobs in flight per phase, range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  **asynchronous, active-low** reset.
- `start`  in  1  one-cycle request to run one inference; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE is exited.
- `done`  out  1  one-cycle pulse when all FC results have returned.
- `err`  out  1  sticky; set on an unexpected result; cleared only by reset or an accepted `start`.
- `conv_valid`  out  1  conv job valid.
- `conv_ready`  in  1  conv engine accepts the job.
- `conv_kernel`  out  3  kernel index, 0..NKER-1.
- `conv_row`, `conv_col`  out  5 each  output position, 0..OUT-1, where OUT = IMG-KSZ+1 = 24.
- `conv_base`  out  15  bit offset of the window's top-left pixel in the packed image, 896·row + 32·col.
- `conv_res_valid`  in  1  one conv result returned.
- `fc_valid`  out  1  FC job valid.
- `fc_ready`  in  1  FC engine accepts the job.
- `fc_neuron`  out  4  neuron index, 0..NCLS-1.
- `fc_res_valid`  in  1  one FC result returned.

## Operation
**States:** IDLE → CONV → CONV_DRAIN → FC → FC_DRAIN → DONE → IDLE.

- **IDLE:** `start` clears all counters and `err`, then moves to CONV.
- **CONV:** indices walk with `col` innermost, then `row`, then `kernel`. Total 8·24·24 = 4608 jobs.
  - The walk advances only on `conv_valid && conv_ready`.
  - After the job (7, 23, 23) is accepted, the state moves to CONV_DRAIN.
- **CONV_DRAIN:** waits until the returned count equals 4608, then moves to FC.
- **FC:** issues neurons 0..9, one per handshake. After neuron 9 is accepted, the state moves to FC_DRAIN.
- **FC_DRAIN:** waits for 10 returns, then moves to DONE.
- **DONE:** `done`=1 for exactly one cycle, then the state moves to IDLE.

**Credit limit:**
- outstanding = issued − returned, kept per phase in a 13-bit up/down counter.
- `*_valid` rises only when the registered outstanding < MAX_OUT.
- A return in the same cycle does not grant credit until the next cycle.
- Once `*_valid` is raised, it and its index/base outputs stay stable until the handshake completes.

**Simultaneous events:** an issue and a return in the same cycle leave outstanding unchanged.

**Errors:**
- `conv_res_valid` with outstanding = 0, or received outside CONV/CONV_DRAIN, sets `err` and is ignored. The same rule applies to `fc_res_valid` outside FC/FC_DRAIN.
- `start` while `busy` is ignored and does not set `err`.

**Arithmetic:** `conv_base` is computed as (row<<9) + (row<<8) + (row<<7) + (col<<5), using no multiplier. The maximum value is 896·23 + 32·23 = 21344, which fits in 15 bits.

## Timing
- **Reset values:** state = IDLE; all outputs and counters 0.
- **Start latency:**
  - `start` at cycle t → `busy`=1 and `conv_valid`=1 at t+1, carrying (0, 0, 0).
  - With `conv_ready` tied high and results returning within MAX_OUT cycles, one job is issued per cycle.
- **Indices:** advance in the cycle after the handshake. `conv_base` is registered alongside them.
- **Phase transitions:**
  - The last conv return at cycle t → `fc_valid`=1 at t+1.
  - The last FC return at t → `done`=1 at t+1, then `busy`=0 at t+2.
- **Reset mid-operation:** all outputs drop to 0 asynchronously. In-flight results arriving after reset is released are treated as unexpected and set `err`.

## Structure
- **Package `cnn_pkg`:** holds IMG, KSZ, OUT, NKER, NCLS, the total conv job count (4608), the row stride (896) and pixel width (32), and the state enum `sched_state_t`.
- **Sub-module `cnn_idx_walker`:** a nested wrap counter (col/row/kernel) with an advance input and a last flag. It is instantiated once for conv; the FC phase uses a plain 4-bit counter.

## Test plan
- **Free-running run:** reset, `start`, ready high, each result returned 2 cycles after issue. Required:
  - 4608 conv jobs in order;
  - first `conv_base`=0;
  - job (0, 1, 0) has base 896;
  - job (0, 23, 23) has base 21344;
  - then 10 FC jobs;
  - `done` pulses once, `err`=0.
- **Backpressure:** `conv_ready` low for 5 cycles with `conv_valid`=1. Required: valid, kernel, row, col and base held constant; no index skip.
- **Credit limit:** MAX_OUT=4, no results returned. Required: exactly 4 jobs issued, then `conv_valid`=0. One return → one more job, starting the next cycle.
- **Simultaneous issue and return:** handshake and result in the same cycle at outstanding=3. Required: outstanding stays 3; the next cycle has `conv_valid`=1.
- **Error cases:**
  - `fc_res_valid` during CONV → `err`=1 and persists through `done`.
  - `start` during CONV → ignored.
- **Reset mid-run:** assert `rst` low at job 1000. Required: outputs return to 0 immediately. A later `start` restarts from (0, 0, 0) with `err`=0.
